// File: rtl/uart_rx_framer.sv
// uart_rx_framer: turns a uart_rx byte stream into checksummed packets (SOF, LEN, payload, CHK).
// Optional idle timeout inside a frame is enabled by defining UART_RX_FRAMER_TIMEOUT_EN.
module uart_rx_framer #(
  parameter int          MAX_LEN        = 16,
  parameter logic [7:0]  SOF_BYTE       = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);
  // state   | meaning
  // IDLE    | hunting for SOF_BYTE
  // LEN     | waiting for the length byte
  // PAYLOAD | storing payload bytes and accumulating the sum
  // CHK     | waiting for the checksum byte
  // DRAIN   | releasing the buffered payload on the output stream
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  if (MAX_LEN < 2 || MAX_LEN > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_rx_framer: unsupported parameter values");
  end

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;

  state_t          state, state_n;
  logic [LW-1:0]   len, len_n, wr_idx, wr_idx_n, rd_idx, rd_idx_n, last_idx;
  logic [7:0]      sum, sum_n, chk_sum;
  logic            frame_ok_n, frame_err_n, buf_we, xfer, timed_out;
  logic [1:0]      err_code_n;
  logic [7:0]      buf_mem [MAX_LEN];

  assign last_idx  = len - LW'(1);
  assign chk_sum   = sum + rx_data;
  assign out_valid = (state == S_DRAIN);
  assign out_data  = buf_mem[rd_idx[IW-1:0]];
  assign out_last  = out_valid && (rd_idx == last_idx);
  assign busy      = (state != S_IDLE);
  assign xfer      = out_valid && out_ready;

`ifdef UART_RX_FRAMER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt, idle_cnt_n;

  // Counts consecutive byte-free cycles while a frame is being received.
  always_comb begin
    idle_cnt_n = '0;
    timed_out  = 1'b0;
    if ((state == S_LEN || state == S_PAYLOAD || state == S_CHK) && !rx_valid) begin
      if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) timed_out = 1'b1;
      else idle_cnt_n = idle_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_cnt <= '0;
    else     idle_cnt <= idle_cnt_n;
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    len_n       = len;
    wr_idx_n    = wr_idx;
    rd_idx_n    = rd_idx;
    sum_n       = sum;
    frame_ok_n  = 1'b0;
    frame_err_n = 1'b0;
    err_code_n  = err_code;
    buf_we      = 1'b0;
    case (state)
      S_IDLE:
        if (rx_valid && rx_data == SOF_BYTE) state_n = S_LEN;
      S_LEN:
        if (rx_valid) begin
          if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
            frame_err_n = 1'b1;
            err_code_n  = 2'd0;
            state_n     = S_IDLE;
          end else begin
            len_n    = rx_data[LW-1:0];
            sum_n    = rx_data;
            wr_idx_n = '0;
            rd_idx_n = '0;
            state_n  = S_PAYLOAD;
          end
        end
      S_PAYLOAD:
        if (rx_valid) begin
          buf_we   = 1'b1;
          sum_n    = chk_sum;
          wr_idx_n = wr_idx + LW'(1);
          if (wr_idx == last_idx) state_n = S_CHK;
        end
      S_CHK:
        if (rx_valid) begin
          if (chk_sum == 8'd0) begin
            frame_ok_n = 1'b1;
            state_n    = S_DRAIN;
          end else begin
            frame_err_n = 1'b1;
            err_code_n  = 2'd1;
            state_n     = S_IDLE;
          end
        end
      S_DRAIN: begin
        // Bytes arriving while draining are dropped; the drain itself carries on.
        if (rx_valid) begin
          frame_err_n = 1'b1;
          err_code_n  = 2'd3;
        end
        if (xfer) begin
          rd_idx_n = rd_idx + LW'(1);
          if (out_last) state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (timed_out) begin
      frame_err_n = 1'b1;
      err_code_n  = 2'd2;
      state_n     = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      len       <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      sum       <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      state     <= state_n;
      len       <= len_n;
      wr_idx    <= wr_idx_n;
      rd_idx    <= rd_idx_n;
      sum       <= sum_n;
      frame_ok  <= frame_ok_n;
      frame_err <= frame_err_n;
      err_code  <= err_code_n;
    end
  end

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[wr_idx[IW-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed self-checking bench for uart_rx_framer (MAX_LEN=16, TIMEOUT_CYCLES=8).
// Checksum bytes are derived from LEN + payload + CHK == 0 mod 256.
module tb_uart_rx_framer;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  // observation state filled by the negedge monitor
  logic [7:0] q_data[$];
  bit         q_last[$];
  int         n_ok, n_err, n_valid_cyc, stall_bad;
  logic [1:0] seen_code;
  bit         prev_stall;
  logic [7:0] prev_data;
  logic       prev_last;

  uart_rx_framer #(.MAX_LEN(16), .SOF_BYTE(8'hA5), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_ok(frame_ok), .frame_err(frame_err),
    .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        q_data.push_back(out_data);
        q_last.push_back(out_last);
      end
      if (out_valid) n_valid_cyc++;
      if (frame_ok) n_ok++;
      if (frame_err) begin
        n_err++;
        seen_code = err_code;
      end
      if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
        stall_bad++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  task automatic clear_mon();
    q_data.delete();
    q_last.delete();
    n_ok = 0; n_err = 0; n_valid_cyc = 0; stall_bad = 0; seen_code = 2'bx;
  endtask

  // Tasks start and end 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic drain_wait();
    for (int i = 0; i < 40 && busy; i++) begin @(posedge clk); #1; end
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL drain_done: busy=%b want 0", busy); n_bad++; end
  endtask

  task automatic send_good(input logic [7:0] p0, p1, p2);
    send_byte(8'hA5); send_byte(8'h03);
    send_byte(p0); send_byte(p1); send_byte(p2);
    send_byte(8'h00 - 8'h03 - p0 - p1 - p2);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; out_ready = 1'b1;
    idle(3);
    n_cmp++; if (out_valid !== 1'b0) begin $display("FAIL rst_out_valid: got %b want 0", out_valid); n_bad++; end
    n_cmp++; if (out_last  !== 1'b0) begin $display("FAIL rst_out_last: got %b want 0", out_last); n_bad++; end
    n_cmp++; if (frame_ok  !== 1'b0) begin $display("FAIL rst_frame_ok: got %b want 0", frame_ok); n_bad++; end
    n_cmp++; if (frame_err !== 1'b0) begin $display("FAIL rst_frame_err: got %b want 0", frame_err); n_bad++; end
    n_cmp++; if (err_code  !== 2'd0) begin $display("FAIL rst_err_code: got %0d want 0", err_code); n_bad++; end
    n_cmp++; if (busy      !== 1'b0) begin $display("FAIL rst_busy: got %b want 0", busy); n_bad++; end
    rst = 1'b0;
    idle(1);
  endtask

  // A5 03 11 22 33 97: 03+11+22+33 = 69, 69+97 = 100
  task automatic test_good_frame();
    clear_mon(); out_ready = 1'b1;
    send_byte(8'h5A); send_byte(8'h00);
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL idle_noise_busy: got %b want 0", busy); n_bad++; end
    send_good(8'h11, 8'h22, 8'h33);
    n_cmp++; if (frame_ok !== 1'b1) begin $display("FAIL good_frame_ok_latency: got %b want 1", frame_ok); n_bad++; end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin
      $display("FAIL good_first_out: valid=%b data=%h want 1/11", out_valid, out_data); n_bad++; end
    drain_wait();
    idle(2);
    n_cmp++; if (n_ok !== 1 || n_err !== 0) begin $display("FAIL good_strobes: ok=%0d err=%0d want 1/0", n_ok, n_err); n_bad++; end
    n_cmp++; if (q_data.size() !== 3 || {q_data[0], q_data[1], q_data[2]} !== 24'h112233) begin
      $display("FAIL good_data: n=%0d got %h%h%h want 112233", q_data.size(), q_data[0], q_data[1], q_data[2]); n_bad++; end
    n_cmp++; if ({q_last[0], q_last[1], q_last[2]} !== 3'b001) begin
      $display("FAIL good_last: got %b%b%b want 001", q_last[0], q_last[1], q_last[2]); n_bad++; end
    n_cmp++; if (out_valid !== 1'b0) begin $display("FAIL good_valid_after: got %b want 0", out_valid); n_bad++; end
  endtask

  task automatic test_backpressure();
    clear_mon(); out_ready = 1'b0;
    send_good(8'h11, 8'h22, 8'h33);
    for (int i = 0; i < 40 && busy; i++) begin
      @(posedge clk); #1;
      out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    idle(2);
    n_cmp++; if (q_data.size() !== 3 || {q_data[0], q_data[1], q_data[2]} !== 24'h112233) begin
      $display("FAIL bp_data: n=%0d got %h%h%h want 112233", q_data.size(), q_data[0], q_data[1], q_data[2]); n_bad++; end
    n_cmp++; if ({q_last[0], q_last[1], q_last[2]} !== 3'b001) begin
      $display("FAIL bp_last: got %b%b%b want 001", q_last[0], q_last[1], q_last[2]); n_bad++; end
    n_cmp++; if (stall_bad !== 0) begin $display("FAIL bp_stable: unstable stalls=%0d want 0", stall_bad); n_bad++; end
    n_cmp++; if (busy !== 1'b0 || n_ok !== 1) begin $display("FAIL bp_done: busy=%b ok=%0d want 0/1", busy, n_ok); n_bad++; end
  endtask

  task automatic test_bad_chk();
    clear_mon(); out_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h00);
    n_cmp++; if (frame_err !== 1'b1 || err_code !== 2'd1) begin
      $display("FAIL badchk_err: err=%b code=%0d want 1/1", frame_err, err_code); n_bad++; end
    n_cmp++; if (frame_ok !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL badchk_state: ok=%b busy=%b want 0/0", frame_ok, busy); n_bad++; end
    idle(4);
    n_cmp++; if (n_valid_cyc !== 0) begin $display("FAIL badchk_no_valid: valid cycles=%0d want 0", n_valid_cyc); n_bad++; end
    clear_mon();
    send_good(8'h44, 8'h55, 8'h66);
    drain_wait();
    idle(1);
    n_cmp++; if (n_ok !== 1 || q_data.size() !== 3 || {q_data[0], q_data[1], q_data[2]} !== 24'h445566) begin
      $display("FAIL badchk_recover: ok=%0d n=%0d data=%h%h%h want 1/3/445566", n_ok, q_data.size(), q_data[0], q_data[1], q_data[2]); n_bad++; end
  endtask

  task automatic test_bad_len();
    clear_mon(); out_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h00);
    n_cmp++; if (frame_err !== 1'b1 || err_code !== 2'd0) begin
      $display("FAIL len0_err: err=%b code=%0d want 1/0", frame_err, err_code); n_bad++; end
    send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
    n_cmp++; if (busy !== 1'b0 || n_err !== 1) begin
      $display("FAIL len0_after: busy=%b errs=%0d want 0/1", busy, n_err); n_bad++; end
    // move err_code away from 0 first so the next code-0 report is visible
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
    idle(1);
    send_byte(8'hA5); send_byte(8'h11);
    n_cmp++; if (frame_err !== 1'b1 || err_code !== 2'd0) begin
      $display("FAIL len17_err: err=%b code=%0d want 1/0", frame_err, err_code); n_bad++; end
    send_byte(8'h05); send_byte(8'h06);
    n_cmp++; if (busy !== 1'b0 || n_err !== 3 || n_ok !== 0) begin
      $display("FAIL len17_after: busy=%b errs=%0d oks=%0d want 0/3/0", busy, n_err, n_ok); n_bad++; end
    // LEN = 16 is the largest legal length
    clear_mon();
    send_byte(8'hA5); send_byte(8'h10);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    send_byte(8'h00 - 8'h10 - 8'h78);
    n_cmp++; if (frame_ok !== 1'b1) begin $display("FAIL len16_ok: got %b want 1", frame_ok); n_bad++; end
    drain_wait();
    idle(1);
    n_cmp++; if (q_data.size() !== 16 || q_data[15] !== 8'h0F || q_last[15] !== 1'b1 || q_last[14] !== 1'b0) begin
      $display("FAIL len16_data: n=%0d last_byte=%h flags=%b%b want 16/0f/01", q_data.size(), q_data[15], q_last[14], q_last[15]); n_bad++; end
  endtask

  task automatic test_overrun();
    clear_mon(); out_ready = 1'b0;
    send_good(8'h11, 8'h22, 8'h33);
    idle(2);
    send_byte(8'h5A);
    n_cmp++; if (frame_err !== 1'b1 || err_code !== 2'd3) begin
      $display("FAIL ovr_err: err=%b code=%0d want 1/3", frame_err, err_code); n_bad++; end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h11 || frame_ok !== 1'b0) begin
      $display("FAIL ovr_hold: valid=%b data=%h ok=%b want 1/11/0", out_valid, out_data, frame_ok); n_bad++; end
    send_byte(8'hA5);
    idle(1);
    out_ready = 1'b1;
    drain_wait();
    idle(3);
    n_cmp++; if (q_data.size() !== 3 || {q_data[0], q_data[1], q_data[2]} !== 24'h112233) begin
      $display("FAIL ovr_data: n=%0d got %h%h%h want 112233", q_data.size(), q_data[0], q_data[1], q_data[2]); n_bad++; end
    n_cmp++; if (busy !== 1'b0 || n_err !== 2 || err_code !== 2'd3 || stall_bad !== 0) begin
      $display("FAIL ovr_after: busy=%b errs=%0d code=%0d stalls=%0d want 0/2/3/0", busy, n_err, err_code, stall_bad); n_bad++; end
  endtask

  // A5 02 11 (pause) 22 CB: 02+11+22 = 35, 35+CB = 100
  task automatic test_timeout();
    clear_mon(); out_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
`ifdef UART_RX_FRAMER_TIMEOUT_EN
    idle(7);
    n_cmp++; if (frame_err !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL to_early: err=%b busy=%b want 0/1", frame_err, busy); n_bad++; end
    idle(1);
    n_cmp++; if (frame_err !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0) begin
      $display("FAIL to_fire: err=%b code=%0d busy=%b want 1/2/0", frame_err, err_code, busy); n_bad++; end
`else
    idle(20);
    n_cmp++; if (n_err !== 0 || busy !== 1'b1) begin
      $display("FAIL to_wait: errs=%0d busy=%b want 0/1", n_err, busy); n_bad++; end
    send_byte(8'h22); send_byte(8'hCB);
    n_cmp++; if (frame_ok !== 1'b1) begin $display("FAIL to_complete: ok=%b want 1", frame_ok); n_bad++; end
    drain_wait();
    idle(1);
    n_cmp++; if (q_data.size() !== 2 || {q_data[0], q_data[1]} !== 16'h1122 || q_last[1] !== 1'b1) begin
      $display("FAIL to_data: n=%0d got %h%h last=%b want 1122/1", q_data.size(), q_data[0], q_data[1], q_last[1]); n_bad++; end
`endif
  endtask

  task automatic test_reset_mid_frame();
    clear_mon(); out_ready = 1'b0;
    send_good(8'h01, 8'h02, 8'h03);
    rst = 1'b1; idle(1);
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0 || frame_err !== 1'b0) begin
      $display("FAIL rst_mid: busy=%b valid=%b err=%b want 0/0/0", busy, out_valid, frame_err); n_bad++; end
    rst = 1'b0; out_ready = 1'b1; idle(1);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_backpressure();
    test_bad_chk();
    test_bad_len();
    test_overrun();
    test_timeout();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
